// File: rtl/front_panel_loader.sv
// front_panel_loader: Altair-style front panel (load/examine/deposit) on shared SRAM; optional FRONT_PANEL_DEBOUNCE_EN key debounce
module front_panel_loader #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            sw,
  input  logic                  sel_hi,
  input  logic                  auto_inc,
  input  logic                  run,
  input  logic [3:0]            key_n,
  input  logic [7:0]            sram_dq_in,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_dq_out,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [7:0]            disp_data
);
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  state_t state, next;
  logic [2:0] s1, s2, lvl, lvl_q, press;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0] data, dq_out;
  logic inc, hold, go, ld, ex, dp, last;
  logic unused_key;
  assign unused_key = key_n[3];
  // key synchronizer and previous accepted level, all idling at released
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 3'b111;
      s2 <= 3'b111;
      lvl_q <= 3'b111;
    end else begin
      s1 <= key_n[2:0];
      s2 <= s1;
      lvl_q <= lvl;
    end
  end
`ifdef FRONT_PANEL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic lvl_r;
    logic [CW-1:0] cnt;
    assign lvl[i] = lvl_r;
    // accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
      if (reset) begin
        lvl_r <= 1'b1;
        cnt <= '0;
      end else if (s2[i] == lvl_r) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_r <= s2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_db = DEBOUNCE_CYCLES;
  assign lvl = s2;
`endif
  assign press = lvl_q & ~lvl;
  assign go = (state == IDLE) && !run;
  assign ld = go & press[0];
  assign ex = go & ~press[0] & press[1];
  assign dp = go & ~press[0] & ~press[1] & press[2];
  assign last = (state == RD_SAMPLE) || (state == WR_HOLD);
  // next state and SRAM strobes decoded from the current state
  always_comb begin
    next = state;
    busy = state != IDLE;
    sram_ce_n = state == IDLE;
    sram_oe_n = !(state == RD_SETUP || state == RD_SAMPLE);
    sram_we_n = state != WR_PULSE;
    sram_dq_oe = state == WR_SETUP || state == WR_PULSE || state == WR_HOLD;
    case (state)
      IDLE:      next = ex ? RD_SETUP : dp ? WR_SETUP : IDLE;
      RD_SETUP:  next = RD_SAMPLE;
      WR_SETUP:  next = WR_PULSE;
      WR_PULSE:  next = WR_HOLD;
      default:   next = IDLE;
    endcase
  end
  // state, address, data latches and the registered CPU hold
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      data <= '0;
      dq_out <= '0;
      inc <= 1'b0;
      hold <= 1'b1;
    end else begin
      state <= next;
      hold <= ~run | (next != IDLE);
      if (ld && sel_hi) addr[15:8] <= sw;
      if (ld && !sel_hi) addr[7:0] <= sw;
      if (ex || dp) inc <= auto_inc;
      if (dp) dq_out <= sw;
      if (state == RD_SAMPLE) data <= sram_dq_in;
      if (state == WR_HOLD) data <= dq_out;
      if (last && inc) addr <= addr + 1'b1;
    end
  end
  assign sram_addr = addr;
  assign disp_addr = addr;
  assign disp_data = data;
  assign sram_dq_out = dq_out;
  assign cpu_hold = hold;
endmodule

// File: tb/tb_front_panel_loader.sv
// tb_front_panel_loader: scoreboard bench for front_panel_loader (directed vectors)
module tb_front_panel_loader;
  logic clk = 0, reset = 1, sel_hi = 0, auto_inc = 0, run = 0;
  logic [7:0] sw = 0, sram_dq_in = 0;
  logic [3:0] key_n = 4'hF;
  logic [15:0] sram_addr, disp_addr;
  logic [7:0] sram_dq_out, disp_data;
  logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, cpu_hold, busy;
  int passed = 0, total = 0, rd_len = 0;
  logic [23:0] wq[$], rq[$];
`ifdef FRONT_PANEL_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 50000;
`endif
  front_panel_loader #(.DEBOUNCE_CYCLES(DB), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .sw(sw), .sel_hi(sel_hi), .auto_inc(auto_inc), .run(run),
    .key_n(key_n), .sram_dq_in(sram_dq_in), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .cpu_hold(cpu_hold), .busy(busy), .disp_addr(disp_addr), .disp_data(disp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s got=%h exp=%h", n, a, e);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input int k);
    key_n[k] = 1'b0;
    tick(6);
    key_n[k] = 1'b1;
    tick(10);
  endtask
  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      tick(1);
      n++;
    end
    chk("busy_seen", {31'd0, busy}, 1);
  endtask
  // monitor: every we_n-low cycle consumes one expected write; every completed read consumes one expected read
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset) rd_len = 0;
    else begin
      if (!sram_we_n) begin
        if (wq.size() == 0) begin
          total++;
          $display("FAIL unexpected_write addr=%h data=%h", sram_addr, sram_dq_out);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", {16'd0, sram_addr}, {16'd0, e[23:8]});
          chk("wr_data", {24'd0, sram_dq_out}, {24'd0, e[7:0]});
          chk("wr_oe", {30'd0, sram_dq_oe, sram_oe_n}, 3);
        end
      end
      if (!sram_oe_n) rd_len++;
      else if (rd_len != 0) begin
        if (rq.size() == 0) begin
          total++;
          $display("FAIL unexpected_read addr=%h", disp_addr);
        end else begin
          e = rq.pop_front();
          chk("rd_len", rd_len, 2);
          chk("rd_addr", {16'd0, disp_addr}, {16'd0, e[23:8]});
          chk("rd_data", {24'd0, disp_data}, {24'd0, e[7:0]});
        end
        rd_len = 0;
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk("rst_addr", {16'd0, disp_addr}, 0);
    chk("rst_data", {24'd0, disp_data}, 0);
    chk("rst_dq_out", {24'd0, sram_dq_out}, 0);
    chk("rst_strobes", {28'd0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 4'b0111);
    chk("rst_busy_hold", {30'd0, busy, cpu_hold}, 2'b01);
    reset = 0;
    tick(2);
    sw = 8'h12; sel_hi = 1; press(0);
    chk("load_hi", {16'd0, disp_addr}, 32'h1200);
    sw = 8'h34; sel_hi = 0; press(0);
    chk("load_lo", {16'd0, disp_addr}, 32'h1234);
    chk("load_no_busy", {31'd0, busy}, 0);
    sw = 8'hA5; wq.push_back(24'h1234A5); press(2);
    chk("dep_disp_data", {24'd0, disp_data}, 32'hA5);
    chk("dep_addr_noinc", {16'd0, disp_addr}, 32'h1234);
    sw = 8'hFF; sel_hi = 1; press(0);
    sel_hi = 0; press(0);
    chk("load_ffff", {16'd0, disp_addr}, 32'hFFFF);
    auto_inc = 1; sram_dq_in = 8'h3C; rq.push_back(24'h00003C); press(1);
    chk("wrap_addr", {16'd0, disp_addr}, 0);
    auto_inc = 0; sram_dq_in = 8'h5A; rq.push_back(24'h00005A);
    key_n = 4'b1001; tick(6); key_n = 4'hF; tick(10);
    chk("prio_data", {24'd0, disp_data}, 32'h5A);
`ifndef FRONT_PANEL_DEBOUNCE_EN
    sw = 8'h77; wq.push_back(24'h000077);
    key_n[2] = 0; tick(2); key_n[2] = 1; tick(1);
    key_n[2] = 0; tick(2); key_n[2] = 1; tick(10);
    chk("discard_data", {24'd0, disp_data}, 32'h77);
`endif
    auto_inc = 1; sw = 8'h66; wq.push_back(24'h000066);
    key_n[2] = 0; wait_busy(); run = 1;
    tick(1);
    chk("hold_mid_write", {31'd0, cpu_hold}, 1);
    key_n[2] = 1; tick(10);
    chk("run_hold", {31'd0, cpu_hold}, 0);
    chk("run_strobes", {28'd0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 4'b0111);
    chk("run_inc_addr", {16'd0, disp_addr}, 1);
    sw = 8'h99; press(0); press(1); press(2);
    chk("run_ignore_addr", {16'd0, disp_addr}, 1);
    chk("run_ignore_data", {24'd0, disp_data}, 32'h66);
    run = 0; auto_inc = 0; sram_dq_in = 8'hC3; tick(2);
    chk("hold_back", {31'd0, cpu_hold}, 1);
`ifdef FRONT_PANEL_DEBOUNCE_EN
    repeat (4) begin key_n[1] = 0; tick(2); key_n[1] = 1; tick(2); end
    tick(8);
    chk("bounce_no_cmd", {24'd0, disp_data}, 32'h66);
    rq.push_back(24'h0001C3);
    key_n[1] = 0; tick(6); key_n[1] = 1; tick(12);
`else
    rq.push_back(24'h0001C3);
    key_n[1] = 0; tick(2); key_n[1] = 1; tick(10);
`endif
    chk("glitch_data", {24'd0, disp_data}, 32'hC3);
    key_n[1] = 0; wait_busy(); reset = 1; key_n[1] = 1;
    tick(1);
    chk("abort_busy", {30'd0, busy, cpu_hold}, 2'b01);
    chk("abort_strobes", {28'd0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 4'b0111);
    chk("abort_addr_data", {8'd0, disp_addr, disp_data}, 0);
    reset = 0; tick(10);
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
